// File: rtl/fpu_pkg.sv
// Shared FPU definitions: rounding-mode codes, flag bit positions, operand
// classes and the canonical quiet-NaN pattern for any exponent/fraction width.
package fpu_pkg;

  localparam logic [1:0] RM_RNE = 2'd0;
  localparam logic [1:0] RM_RTZ = 2'd1;
  localparam logic [1:0] RM_RUP = 2'd2;
  localparam logic [1:0] RM_RDN = 2'd3;

  localparam int FLG_INVALID   = 3;
  localparam int FLG_OVERFLOW  = 2;
  localparam int FLG_UNDERFLOW = 1;
  localparam int FLG_INEXACT   = 0;

  typedef enum logic [1:0] {
    CLS_ZERO,
    CLS_INF,
    CLS_NAN,
    CLS_NORM
  } fp_class_e;

  localparam int QNAN_MAX_W = 128;

  // Sign 0, exponent all ones, fraction MSB set; caller truncates to its width.
  function automatic logic [QNAN_MAX_W-1:0] canonical_qnan(input int expW, input int fracW);
    logic [QNAN_MAX_W-1:0] r;
    r = '0;
    for (int i = 0; i < QNAN_MAX_W; i++) begin
      r[i] = (i == fracW - 1) || ((i >= fracW) && (i < fracW + expW));
    end
    return r;
  endfunction

endpackage

// File: rtl/fmul_pipe_if.sv
// Streaming operand/result bundle of the pipelined multiplier.
interface fmul_pipe_if #(
  parameter int EXP_W  = 8,
  parameter int FRAC_W = 23
);
  localparam int W = 1 + EXP_W + FRAC_W;

  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic [1:0]   rnd_mode;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] result;
  logic [3:0]   flags;

  modport master (
    output in_valid, a, b, rnd_mode, out_ready,
    input  in_ready, out_valid, result, flags
  );

  modport slave (
    input  in_valid, a, b, rnd_mode, out_ready,
    output in_ready, out_valid, result, flags
  );
endinterface

// File: rtl/fp_mant_mult.sv
// Unsigned WxW -> 2W mantissa multiplier, isolated so a DSP or Booth
// implementation can replace it without touching the pipeline.
module fp_mant_mult #(
  parameter int W = 24
) (
  input  logic [W-1:0]   a_i,
  input  logic [W-1:0]   b_i,
  output logic [2*W-1:0] p_o
);
  assign p_o = (2 * W)'(a_i) * (2 * W)'(b_i);
endmodule

// File: rtl/fmul_pipe.sv
// Three-stage floating-point multiplier (classify / multiply / normalise-round)
// with a single global stall so every stage advances together.
module fmul_pipe
  import fpu_pkg::*;
#(
  parameter int EXP_W  = 8,
  parameter int FRAC_W = 23,
  parameter int BIAS   = 2 ** (EXP_W - 1) - 1
) (
  input logic        clk,
  input logic        rst,
  fmul_pipe_if.slave bus
);
  localparam int W   = 1 + EXP_W + FRAC_W;
  localparam int MW  = FRAC_W + 1;
  localparam int PW  = 2 * MW;
  localparam int EW2 = EXP_W + 2;
  localparam logic [W-1:0]          QNAN    = W'(canonical_qnan(EXP_W, FRAC_W));
  localparam logic signed [EW2-1:0] EXP_ONE = EW2'(1);
  localparam logic signed [EW2-1:0] EXP_MAX = EW2'(2 ** EXP_W - 1);

  function automatic fp_class_e classify(input logic [EXP_W-1:0] e, input logic [FRAC_W-1:0] f);
    if (e == '1) return (f == '0) ? CLS_INF : CLS_NAN;
    if (e == '0) return CLS_ZERO;
    return CLS_NORM;
  endfunction

  logic                  outValid_q;
  logic [W-1:0]          result_q, result_d;
  logic [3:0]            flags_q, flags_d;
  logic                  adv;

  logic                  s1Valid_q, s1Sign_q, s1Special_q, s1Invalid_q;
  logic signed [EW2-1:0] s1Exp_q;
  logic [MW-1:0]         s1Ma_q, s1Mb_q;
  logic [1:0]            s1Rm_q;
  logic [W-1:0]          s1SpecRes_q;

  logic                  s2Valid_q, s2Sign_q, s2Special_q, s2Invalid_q;
  logic signed [EW2-1:0] s2Exp_q;
  logic [PW-1:0]         s2Prod_q, prod_d;
  logic [1:0]            s2Rm_q;
  logic [W-1:0]          s2SpecRes_q;

  assign adv           = !outValid_q || bus.out_ready;
  assign bus.in_ready  = adv;
  assign bus.out_valid = outValid_q;
  assign bus.result    = result_q;
  assign bus.flags     = flags_q;

  logic                  sa, sb;
  logic [EXP_W-1:0]      ea, eb;
  logic [FRAC_W-1:0]     fa, fb;
  fp_class_e             ca, cb;
  logic                  sign_d, special_d, invalid_d;
  logic signed [EW2-1:0] expSum_d;
  logic [W-1:0]          specRes_d;

  assign {sa, ea, fa} = bus.a;
  assign {sb, eb, fb} = bus.b;
  assign ca = classify(ea, fa);
  assign cb = classify(eb, fb);

  // S1: special-case priority NaN > inf*0 > inf > zero; subnormals classify as zero
  always_comb begin
    sign_d    = sa ^ sb;
    expSum_d  = EW2'(ea) + EW2'(eb) - EW2'(BIAS);
    special_d = 1'b1;
    invalid_d = 1'b0;
    specRes_d = '0;
    if (ca == CLS_NAN || cb == CLS_NAN) begin
      specRes_d = QNAN;
      invalid_d = (ca == CLS_NAN && !fa[FRAC_W-1]) || (cb == CLS_NAN && !fb[FRAC_W-1]);
    end else if ((ca == CLS_INF && cb == CLS_ZERO) || (ca == CLS_ZERO && cb == CLS_INF)) begin
      specRes_d = QNAN;
      invalid_d = 1'b1;
    end else if (ca == CLS_INF || cb == CLS_INF) begin
      specRes_d = {sign_d, {EXP_W{1'b1}}, {FRAC_W{1'b0}}};
    end else if (ca == CLS_ZERO || cb == CLS_ZERO) begin
      specRes_d = {sign_d, {(W-1){1'b0}}};
    end else begin
      special_d = 1'b0;
    end
  end

  fp_mant_mult #(.W(MW)) uMantMult (
    .a_i(s1Ma_q),
    .b_i(s1Mb_q),
    .p_o(prod_d)
  );

  logic [FRAC_W-1:0]     mant, mantR;
  logic                  guard, sticky, inc, carry, toInf;
  logic signed [EW2-1:0] expN, expR;

  // S3: underflow judged on the normalised exponent, overflow after rounding
  always_comb begin
    expN = s2Exp_q + EW2'(s2Prod_q[PW-1]);
    if (s2Prod_q[PW-1]) begin
      mant   = s2Prod_q[PW-2 -: FRAC_W];
      guard  = s2Prod_q[PW-2-FRAC_W];
      sticky = |s2Prod_q[PW-3-FRAC_W:0];
    end else begin
      mant   = s2Prod_q[PW-3 -: FRAC_W];
      guard  = s2Prod_q[PW-3-FRAC_W];
      sticky = |s2Prod_q[PW-4-FRAC_W:0];
    end
    case (s2Rm_q)
      RM_RNE:  inc = guard & (sticky | mant[0]);
      RM_RTZ:  inc = 1'b0;
      RM_RUP:  inc = !s2Sign_q & (guard | sticky);
      default: inc = s2Sign_q & (guard | sticky);
    endcase
    {carry, mantR} = {1'b0, mant} + {{FRAC_W{1'b0}}, inc};
    expR  = expN + EW2'(carry);
    toInf = (s2Rm_q == RM_RNE) || (s2Rm_q == RM_RUP && !s2Sign_q) ||
            (s2Rm_q == RM_RDN && s2Sign_q);

    result_d = {s2Sign_q, expR[EXP_W-1:0], mantR};
    flags_d  = '0;
    flags_d[FLG_INEXACT] = guard | sticky;
    if (s2Special_q) begin
      result_d = s2SpecRes_q;
      flags_d  = '0;
      flags_d[FLG_INVALID] = s2Invalid_q;
    end else if (expN < EXP_ONE) begin
      result_d = {s2Sign_q, {(W-1){1'b0}}};
      flags_d[FLG_UNDERFLOW] = 1'b1;
      flags_d[FLG_INEXACT]   = 1'b1;
    end else if (expR >= EXP_MAX) begin
      result_d = toInf ? {s2Sign_q, {EXP_W{1'b1}}, {FRAC_W{1'b0}}}
                       : {s2Sign_q, {(EXP_W-1){1'b1}}, 1'b0, {FRAC_W{1'b1}}};
      flags_d[FLG_OVERFLOW] = 1'b1;
      flags_d[FLG_INEXACT]  = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1Valid_q  <= 1'b0;
      s2Valid_q  <= 1'b0;
      outValid_q <= 1'b0;
      result_q   <= '0;
      flags_q    <= '0;
    end else if (adv) begin
      s1Valid_q  <= bus.in_valid;
      s2Valid_q  <= s1Valid_q;
      outValid_q <= s2Valid_q;
      result_q   <= result_d;
      flags_q    <= flags_d;
    end
  end

  always_ff @(posedge clk) begin
    if (adv) begin
      s1Sign_q    <= sign_d;
      s1Exp_q     <= expSum_d;
      s1Ma_q      <= {1'b1, fa};
      s1Mb_q      <= {1'b1, fb};
      s1Rm_q      <= bus.rnd_mode;
      s1Special_q <= special_d;
      s1SpecRes_q <= specRes_d;
      s1Invalid_q <= invalid_d;
      s2Sign_q    <= s1Sign_q;
      s2Exp_q     <= s1Exp_q;
      s2Prod_q    <= prod_d;
      s2Rm_q      <= s1Rm_q;
      s2Special_q <= s1Special_q;
      s2SpecRes_q <= s1SpecRes_q;
      s2Invalid_q <= s1Invalid_q;
    end
  end

endmodule

// File: tb/tb_fmul_pipe.sv
// Bench for fmul_pipe (binary32): a real-arithmetic reference model feeds a
// scoreboard that is compared against every result the DUT hands over.
module tb_fmul_pipe;
  import fpu_pkg::*;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  fmul_pipe_if #(.EXP_W(8), .FRAC_W(23)) bus ();

  fmul_pipe #(.EXP_W(8), .FRAC_W(23)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  typedef struct packed {
    logic [31:0] res;
    logic [3:0]  flg;
  } exp_t;

  exp_t        expQ[$];
  int          numChecks = 0;
  int          numMiscompares = 0;
  logic        holdValid = 1'b0;
  logic [31:0] holdRes;
  logic [3:0]  holdFlg;
  logic        randDone;

  // Exact product via double precision, then rounded to binary32 by the mode rules
  function automatic exp_t model(input logic [31:0] a, input logic [31:0] b, input logic [1:0] rm);
    exp_t r;
    logic aNan, bNan, aInf, bInf, aZero, bZero, sign, g, st, up, toInf;
    logic [63:0] da, db, pb;
    real p;
    int e, m;
    aNan  = (a[30:23] == 8'hFF) && (a[22:0] != 23'd0);
    bNan  = (b[30:23] == 8'hFF) && (b[22:0] != 23'd0);
    aInf  = (a[30:23] == 8'hFF) && (a[22:0] == 23'd0);
    bInf  = (b[30:23] == 8'hFF) && (b[22:0] == 23'd0);
    aZero = (a[30:23] == 8'h00);
    bZero = (b[30:23] == 8'h00);
    sign  = a[31] ^ b[31];
    r.res = 32'd0;
    r.flg = 4'd0;
    if (aNan || bNan) begin
      r.res = 32'h7FC00000;
      r.flg = {(aNan && !a[22]) || (bNan && !b[22]), 3'b000};
      return r;
    end
    if ((aInf && bZero) || (aZero && bInf)) begin
      r.res = 32'h7FC00000;
      r.flg = 4'b1000;
      return r;
    end
    if (aInf || bInf) begin
      r.res = {sign, 8'hFF, 23'd0};
      return r;
    end
    if (aZero || bZero) begin
      r.res = {sign, 31'd0};
      return r;
    end
    da = {a[31], 11'(int'(a[30:23]) + 896), a[22:0], 29'd0};
    db = {b[31], 11'(int'(b[30:23]) + 896), b[22:0], 29'd0};
    p  = $bitstoreal(da) * $bitstoreal(db);
    pb = $realtobits(p);
    e  = int'(pb[62:52]) - 896;
    m  = int'(pb[51:29]);
    g  = pb[28];
    st = |pb[27:0];
    if (e < 1) begin
      r.res = {sign, 31'd0};
      r.flg = 4'b0011;
      return r;
    end
    case (rm)
      RM_RNE:  up = g && (st || m[0]);
      RM_RTZ:  up = 1'b0;
      RM_RUP:  up = !sign && (g || st);
      default: up = sign && (g || st);
    endcase
    m = m + int'(up);
    if (m == 32'h0080_0000) begin
      m = 0;
      e = e + 1;
    end
    if (e >= 255) begin
      toInf = (rm == RM_RNE) || (rm == RM_RUP && !sign) || (rm == RM_RDN && sign);
      r.res = toInf ? {sign, 8'hFF, 23'd0} : {sign, 8'hFE, 23'h7FFFFF};
      r.flg = 4'b0101;
      return r;
    end
    r.res = {sign, e[7:0], m[22:0]};
    r.flg = {3'b000, g || st};
    return r;
  endfunction

  function automatic logic [31:0] randOp();
    logic [7:0]  e;
    logic [22:0] f;
    e = 8'($urandom_range(1, 254));
    f = 23'($urandom);
    case ($urandom_range(0, 15))
      0: begin
        e = 8'h00;
        if ($urandom_range(0, 1) == 0) f = 23'd0;
      end
      1: begin
        e = 8'hFF;
        f = 23'd0;
      end
      2: e = 8'hFF;
      3: f = 23'h7FFFFF;
      4: e = 8'($urandom_range(120, 134));
      default: ;
    endcase
    return {1'($urandom), e, f};
  endfunction

  task automatic checkValue(input string name, input logic [39:0] act, input logic [39:0] req);
    numChecks++;
    if (act !== req) begin
      numMiscompares++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
    end
  endtask

  task automatic checkOutput(input string name, input logic [31:0] res, input logic [3:0] flg,
                             input logic [31:0] expRes, input logic [3:0] expFlg);
    checkValue(name, 40'({res, flg}), 40'({expRes, expFlg}));
  endtask

  // Called just after a rising edge; returns just after the edge that accepted the pair
  task automatic applyStimulus(input logic [31:0] a, input logic [31:0] b, input logic [1:0] rm);
    int waited;
    bus.a        = a;
    bus.b        = b;
    bus.rnd_mode = rm;
    bus.in_valid = 1'b1;
    waited       = 0;
    @(negedge clk);
    while (!bus.in_ready && waited < 300) begin
      @(negedge clk);
      waited++;
    end
    if (waited >= 300) checkValue("accept timeout", 40'(bus.in_ready), 40'd1);
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
  endtask

  task automatic runDirected(input string name, input logic [31:0] a, input logic [31:0] b,
                             input logic [1:0] rm, input logic [31:0] expRes, input logic [3:0] expFlg);
    exp_t m;
    int   lat;
    m = model(a, b, rm);
    checkOutput({"model ", name}, m.res, m.flg, expRes, expFlg);
    applyStimulus(a, b, rm);
    lat = 1;
    while (!bus.out_valid && lat < 20) begin
      @(posedge clk);
      #1;
      lat++;
    end
    checkValue({name, " latency"}, 40'(lat), 40'd3);
    checkOutput(name, bus.result, bus.flags, expRes, expFlg);
  endtask

  task automatic drain();
    bus.out_ready = 1'b1;
    repeat (12) @(posedge clk);
    #1;
    checkValue("drain queue empty", 40'(expQ.size()), 40'd0);
    checkValue("drain out_valid", 40'(bus.out_valid), 40'd0);
  endtask

  // Scoreboard: every handshake either pushes a model result or pops and compares one
  always @(negedge clk) begin : monitor
    exp_t e;
    if (rst) begin
      expQ.delete();
      holdValid = 1'b0;
    end else begin
      if (holdValid)
        checkValue("stall hold", 40'({bus.out_valid, bus.result, bus.flags}),
                   40'({1'b1, holdRes, holdFlg}));
      if (bus.out_valid && bus.out_ready) begin
        if (expQ.size() == 0) begin
          checkValue("spurious out_valid", 40'(bus.out_valid), 40'd0);
        end else begin
          e = expQ.pop_front();
          checkOutput("stream", bus.result, bus.flags, e.res, e.flg);
        end
      end
      holdValid = bus.out_valid && !bus.out_ready;
      holdRes   = bus.result;
      holdFlg   = bus.flags;
      if (bus.in_valid && bus.in_ready) expQ.push_back(model(bus.a, bus.b, bus.rnd_mode));
    end
  end

  initial begin
    logic [31:0] held;
    bus.in_valid  = 1'b0;
    bus.a         = 32'd0;
    bus.b         = 32'd0;
    bus.rnd_mode  = RM_RNE;
    bus.out_ready = 1'b1;
    rst           = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    checkValue("reset out_valid", 40'(bus.out_valid), 40'd0);
    checkValue("reset result", 40'(bus.result), 40'd0);
    checkValue("reset flags", 40'(bus.flags), 40'd0);
    checkValue("reset in_ready", 40'(bus.in_ready), 40'd1);

    runDirected("1.5x2",        32'h3FC00000, 32'h40000000, RM_RNE, 32'h40400000, 4'b0000);
    runDirected("-2x3",         32'hC0000000, 32'h40400000, RM_RNE, 32'hC0C00000, 4'b0000);
    runDirected("inf x 0",      32'h7F800000, 32'h00000000, RM_RNE, 32'h7FC00000, 4'b1000);
    runDirected("sNaN",         32'h7FA00000, 32'h3F800000, RM_RNE, 32'h7FC00000, 4'b1000);
    runDirected("qNaN",         32'h7FC00000, 32'h3F800000, RM_RNE, 32'h7FC00000, 4'b0000);
    runDirected("-inf x 2",     32'hFF800000, 32'h40000000, RM_RNE, 32'hFF800000, 4'b0000);
    runDirected("ovf RNE",      32'h7F000000, 32'h40000000, RM_RNE, 32'h7F800000, 4'b0101);
    runDirected("ovf RTZ",      32'h7F000000, 32'h40000000, RM_RTZ, 32'h7F7FFFFF, 4'b0101);
    runDirected("neg ovf RDN",  32'hFF000000, 32'h40000000, RM_RDN, 32'hFF800000, 4'b0101);
    runDirected("neg ovf RUP",  32'hFF000000, 32'h40000000, RM_RUP, 32'hFF7FFFFF, 4'b0101);
    runDirected("round RNE",    32'h3F800001, 32'h3F800001, RM_RNE, 32'h3F800002, 4'b0001);
    runDirected("round RUP",    32'h3F800001, 32'h3F800001, RM_RUP, 32'h3F800003, 4'b0001);
    runDirected("underflow",    32'h00800000, 32'h3F000000, RM_RNE, 32'h00000000, 4'b0011);
    runDirected("subnormal",    32'h00000001, 32'h3F800000, RM_RNE, 32'h00000000, 4'b0000);
    runDirected("-0 x 1",       32'h80000000, 32'h3F800000, RM_RNE, 32'h80000000, 4'b0000);
    drain();

    $display("[TB] backpressure burst");
    bus.out_ready = 1'b0;
    fork
      begin
        for (int i = 0; i < 5; i++) applyStimulus(randOp(), randOp(), 2'($urandom_range(0, 3)));
      end
      begin
        repeat (5) @(negedge clk);
        checkValue("stall out_valid/in_ready", 40'({bus.out_valid, bus.in_ready}), 40'b10);
        held = bus.result;
        repeat (4) @(negedge clk);
        checkValue("stall result stable", 40'(bus.result), 40'(held));
        @(posedge clk);
        #1;
        bus.out_ready = 1'b1;
      end
    join
    drain();

    $display("[TB] random traffic with random out_ready");
    randDone = 1'b0;
    fork
      begin
        for (int i = 0; i < 400; i++) begin
          if ($urandom_range(0, 3) == 0) begin
            @(posedge clk);
            #1;
          end
          applyStimulus(randOp(), randOp(), 2'($urandom_range(0, 3)));
        end
        randDone = 1'b1;
      end
      begin
        while (!randDone) begin
          @(posedge clk);
          #1;
          bus.out_ready = ($urandom_range(0, 2) != 0);
        end
      end
    join
    drain();

    $display("[TB] reset with pairs in flight");
    bus.out_ready = 1'b0;
    for (int i = 0; i < 3; i++) applyStimulus(randOp(), randOp(), RM_RNE);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    checkValue("mid reset out_valid", 40'(bus.out_valid), 40'd0);
    checkValue("mid reset in_ready", 40'(bus.in_ready), 40'd1);
    checkValue("mid reset result", 40'({bus.result, bus.flags}), 40'd0);
    bus.out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      checkValue("post reset quiet", 40'(bus.out_valid), 40'd0);
    end
    @(posedge clk);
    #1;
    runDirected("after reset", 32'h3FC00000, 32'h40000000, RM_RNE, 32'h40400000, 4'b0000);
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", numChecks, numMiscompares);
    $finish;
  end

endmodule
